// File: rtl/demux2_stream.sv
// demux2_stream
// Steers each message from one valid/ready input stream to one of two output
// streams, chosen by a per-message select bit. Each output owns a small FIFO,
// so a stalled consumer on one side only blocks input traffic addressed to
// that same side.
//
// Handshake semantics (all ports): a transfer happens on a rising clk edge
// where both val and rdy are 1. A producer holding val=1 keeps msg (and sel)
// stable until the transfer. rdy never depends on the val of the same port.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   in_val/in_rdy       input handshake; in_rdy reflects the FIFO chosen by in_sel
//   in_sel              destination: 0 -> out0, 1 -> out1
//   in_msg              input payload (p_nbits)
//   out0_val/out0_rdy   out0 handshake; out0_msg is the head of FIFO 0
//   out1_val/out1_rdy   out1 handshake; out1_msg is the head of FIFO 1
//   count0, count1      occupancy of FIFO 0 / FIFO 1
module demux2_stream #(
    parameter int p_nbits = 8,
    parameter int p_depth = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic                       in_sel,
    input  logic [p_nbits-1:0]         in_msg,
    output logic                       out0_val,
    input  logic                       out0_rdy,
    output logic [p_nbits-1:0]         out0_msg,
    output logic                       out1_val,
    input  logic                       out1_rdy,
    output logic [p_nbits-1:0]         out1_msg,
    output logic [$clog2(p_depth):0]   count0,
    output logic [$clog2(p_depth):0]   count1
);

    localparam int p_aw = $clog2(p_depth);
    localparam int p_cw = p_aw + 1;
    localparam logic [p_cw-1:0] depth_c = p_cw'(p_depth);

    logic [p_nbits-1:0] mem    [2][p_depth];
    logic [p_aw-1:0]    wr_ptr [2];
    logic [p_aw-1:0]    rd_ptr [2];
    logic [p_cw-1:0]    cnt    [2];

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_rdy;

    assign out_rdy = {out1_rdy, out0_rdy};

    // in_rdy looks only at the current occupancy: a full FIFO whose consumer
    // is popping this cycle still refuses input, so the freed slot becomes
    // usable one cycle later and there is no combinational path from
    // outN_rdy to in_rdy.
    always_comb begin
        full[0] = (cnt[0] == depth_c);
        full[1] = (cnt[1] == depth_c);
        in_rdy  = !rst && !(in_sel ? full[1] : full[0]);
        push[0] = in_val && in_rdy && !in_sel;
        push[1] = in_val && in_rdy && in_sel;
        pop[0]  = (cnt[0] != '0) && out_rdy[0];
        pop[1]  = (cnt[1] != '0) && out_rdy[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
                for (int j = 0; j < p_depth; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_msg;
                    // p_depth is a power of two, so natural overflow wraps
                    wr_ptr[i]         <= wr_ptr[i] + p_aw'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + p_aw'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + p_cw'(1);
                    2'b01:   cnt[i] <= cnt[i] - p_cw'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Heads come straight from storage at the read pointer; storage is
    // cleared on reset so the outputs are 0, not X, before any traffic.
    assign out0_val = (cnt[0] != '0);
    assign out1_val = (cnt[1] != '0);
    assign out0_msg = mem[0][rd_ptr[0]];
    assign out1_msg = mem[1][rd_ptr[1]];
    assign count0   = cnt[0];
    assign count1   = cnt[1];

endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- Inverse of the team's 2:1 selector. Takes one valid/ready input stream and steers each message to one of two output streams, chosen by a per-message select bit.
- Each output has its own small FIFO, so a stalled consumer on one side does not block traffic bound for the other side, except through the shared input port.
- Sits between a single producer (e.g. a shared bus or arbiter output) and two independent consumers.

Parameters:
- p_nbits, 8, message width in bits.
- p_depth, 2, entries per output FIFO (power of two, ≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_val  input  1  producer has a valid message.
- in_rdy  output  1  block can accept the message addressed by in_sel.
- in_sel  input  1  destination: 0 → out0, 1 → out1; sampled only on handshake.
- in_msg  input  p_nbits  message payload.
- out0_val  output  1  out0 FIFO non-empty.
- out0_rdy  input  1  consumer 0 accepts.
- out0_msg  output  p_nbits  head of out0 FIFO.
- out1_val  output  1  out1 FIFO non-empty.
- out1_rdy  input  1  consumer 1 accepts.
- out1_msg  output  p_nbits  head of out1 FIFO.
- count0  output  clog2(p_depth)+1  occupancy of out0 FIFO.
- count1  output  clog2(p_depth)+1  occupancy of out1 FIFO.

Behaviour:
- Reset (async, immediate on rst=1, independent of clk):
  - Both FIFOs emptied; count0=count1=0.
  - Read/write pointers cleared; storage cleared to 0.
  - out0_val=out1_val=0; out0_msg=out1_msg=0.
  - Reset mid-operation discards all buffered messages. No handshake completes while rst=1.
- in_rdy (combinational, depends on in_sel): in_rdy = !rst && (count[in_sel] < p_depth).
  - It does not depend on out*_rdy: no full-FIFO pass-through.
- Input handshake: fires when in_val && in_rdy at a rising edge. in_msg is written at the tail of FIFO[in_sel], and that FIFO's count increments.
- Output handshake: fires when outN_val && outN_rdy at a rising edge. The head is popped and countN decrements.
- outN_val = (countN != 0). outN_msg = storage[rd_ptrN], a registered read, never X after reset.
- Latency: a message accepted at edge k is visible at its output after edge k (earliest pop at edge k+1). No same-cycle bypass when empty.
- Same FIFO enqueue + dequeue in the same cycle (count between 1 and p_depth-1, or count=p_depth with enqueue blocked): count unchanged. Pointers both advance. Order is preserved.
- Full FIFO (count=p_depth) with that consumer popping this cycle: in_rdy stays 0 this cycle. The freed slot is usable from the next cycle.
- Independence: enqueue to FIFO A and dequeue from FIFO B in the same cycle update each counter independently.
- Pointers wrap modulo p_depth. Counts never exceed p_depth or go below 0.
- Per-output message order equals acceptance order. No ordering is defined between out0 and out1.
- in_val=0: no state change on the input side, regardless of in_sel/in_msg.
- Message content is never altered; all p_nbits bits pass unchanged.

Test Plan:
- Reset check: assert rst mid-run with count0=2 → out0_val=0, count0=0, out0_msg=0 immediately, before the next clk edge; in_rdy=0 while rst=1.
- Steering: send 0x11 (sel=0), 0x22 (sel=1), 0x33 (sel=0) with both consumers ready → out0 delivers 0x11 then 0x33, out1 delivers 0x22, each one cycle after acceptance.
- Fill and block (p_depth=2):
  - Hold out0_rdy=0 and send 0xA1, 0xA2, 0xA3 to sel=0 → count0=2 and in_rdy=0 for 0xA3.
  - Send 0xB1 to sel=1 meanwhile → accepted, out1_msg=0xB1.
- Full-pop timing: with count0=2, raise out0_rdy for one cycle while presenting 0xA3 → 0xA1 popped, 0xA3 not accepted that cycle, accepted next cycle; out0 order 0xA2, 0xA3.
- Simultaneous enqueue/dequeue at count0=1 (head 0x55), push 0x66 while popping → count0 stays 1, out0_msg=0x66 next cycle.
- Wrap-around: stream 10 messages 0x00..0x09 to sel=1 with out1_rdy toggling every cycle → all 10 received in order, count1 never >2, no loss or duplication.
